// File: rtl/axi_sram_pkg.sv
// Types and helpers shared by the AXI-to-SRAM responder: FSM states,
// AXI encodings and the per-beat address/legality calculations.
package axi_sram_pkg;

`include "axi_defines.svh"

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WRESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = `AXI_BURST_FIXED;
    localparam logic [1:0] BURST_INCR  = `AXI_BURST_INCR;
    localparam logic [1:0] BURST_WRAP  = `AXI_BURST_WRAP;
    localparam logic [1:0] RESP_OKAY   = `AXI_RESP_OKAY;
    localparam logic [1:0] RESP_SLVERR = `AXI_RESP_SLVERR;

    // WRAP keeps the low bits inside an aligned (len+1)<<size byte window.
    function automatic logic [31:0] next_beat_addr(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] incr;
        logic [31:0] sum;
        logic [31:0] mask;
        incr = 32'd1 << size;
        sum  = addr + incr;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_INCR: next_beat_addr = sum;
            BURST_WRAP: next_beat_addr = (addr & ~mask) | (sum & mask);
            default:    next_beat_addr = addr;
        endcase
    endfunction

    function automatic logic burst_illegal(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_illegal = (size > 3'd2) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address and burst legality for the latched request.
module axi_burst_addr (
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        burst_err
);
    import axi_sram_pkg::*;

    assign next_addr = next_beat_addr(addr, len, size, burst);
    assign burst_err = burst_illegal(len, size, burst);

endmodule

// File: rtl/axi_defines.svh
// Shared AXI encodings for burst type and response codes.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH

`define AXI_BURST_FIXED  2'b00
`define AXI_BURST_INCR   2'b01
`define AXI_BURST_WRAP   2'b10

`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_SLVERR  2'b10

`endif

// File: rtl/axi_sram_resp.sv
// Single-outstanding AXI3 slave in front of a synchronous 32-bit SRAM.
// One read or write burst is served at a time; reads stream at one beat per cycle.
module axi_sram_resp #(
    parameter int ID_WIDTH = 10,
    parameter int MEM_AW   = 14
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_WIDTH-1:0] s_awid,
    input  logic [31:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ID_WIDTH-1:0] s_wid,
    input  logic [31:0]         s_wdata,
    input  logic [3:0]          s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_WIDTH-1:0] s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_WIDTH-1:0] s_arid,
    input  logic [31:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_WIDTH-1:0] s_rid,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                sram_cs,
    output logic [3:0]          sram_we,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [31:0]         sram_wdata,
    input  logic [31:0]         sram_rdata
);
    import axi_sram_pkg::*;

    state_t              state_reg;
    logic                prio_rd_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [31:0]         addr_reg;
    logic [7:0]          len_reg;
    logic [2:0]          size_reg;
    logic [1:0]          burst_reg;
    logic [8:0]          beat_cnt_reg;
    logic                rvalid_reg;
    logic                rlast_reg;
    logic [1:0]          rresp_reg;
    logic                rd_fresh_reg;
    logic [31:0]         rdata_hold_reg;
    logic                wr_err_reg;
    logic [1:0]          bresp_reg;

    logic [31:0] next_addr;
    logic        burst_err;
    logic        out_of_range;
    logic        beat_err;
    logic        last_beat;
    logic        accept_ok;
    logic        grant_rd;
    logic        grant_wr;
    logic        rd_issue;
    logic        rd_done;
    logic        w_fire;
    logic        w_final;
    logic        w_err;
    logic        unused_wid;

    axi_burst_addr u_burst_addr (
        .addr      (addr_reg),
        .len       (len_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (next_addr),
        .burst_err (burst_err)
    );

    assign unused_wid   = ^s_wid;
    assign out_of_range = |addr_reg[31:MEM_AW+2];
    assign beat_err     = burst_err | out_of_range;
    assign last_beat    = (beat_cnt_reg == {1'b0, len_reg});

    // Ready strobes are combinational in IDLE, so hold them low while reset is asserted.
    assign accept_ok = rstn && (state_reg == IDLE);
    assign grant_rd  = accept_ok && s_arvalid && (!s_awvalid || prio_rd_reg);
    assign grant_wr  = accept_ok && s_awvalid && !grant_rd;
    assign s_arready = grant_rd;
    assign s_awready = grant_wr;

    assign rd_issue = (state_reg == RD) && (beat_cnt_reg <= {1'b0, len_reg})
                      && (!rvalid_reg || s_rready);
    assign rd_done  = rvalid_reg && s_rready && rlast_reg;

    assign w_fire  = (state_reg == WR) && s_wvalid;
    assign w_final = s_wlast | last_beat;
    assign w_err   = wr_err_reg | beat_err | (s_wlast ^ last_beat);

    // Erroneous beats never touch the SRAM.
    assign sram_cs    = (rd_issue || w_fire) && !beat_err;
    assign sram_we    = (w_fire && !beat_err) ? s_wstrb : 4'b0000;
    assign sram_wdata = (w_fire && !beat_err) ? s_wdata : 32'd0;
    assign sram_addr  = addr_reg[MEM_AW+1:2];

    assign s_wready = (state_reg == WR);
    assign s_bvalid = (state_reg == WRESP);
    assign s_bid    = id_reg;
    assign s_bresp  = bresp_reg;

    assign s_rvalid = rvalid_reg;
    assign s_rlast  = rlast_reg;
    assign s_rresp  = rresp_reg;
    assign s_rid    = id_reg;
    // Fresh SRAM data on the first valid cycle, captured copy while stalled.
    assign s_rdata  = rd_fresh_reg ? sram_rdata : rdata_hold_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            prio_rd_reg    <= 1'b1;
            id_reg         <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
            size_reg       <= '0;
            burst_reg      <= '0;
            beat_cnt_reg   <= '0;
            rvalid_reg     <= 1'b0;
            rlast_reg      <= 1'b0;
            rresp_reg      <= '0;
            rd_fresh_reg   <= 1'b0;
            rdata_hold_reg <= '0;
            wr_err_reg     <= 1'b0;
            bresp_reg      <= '0;
        end else begin
            rd_fresh_reg <= 1'b0;
            if (rd_fresh_reg) begin
                rdata_hold_reg <= sram_rdata;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_rd) begin
                        id_reg       <= s_arid;
                        addr_reg     <= s_araddr;
                        len_reg      <= s_arlen;
                        size_reg     <= s_arsize;
                        burst_reg    <= s_arburst;
                        beat_cnt_reg <= '0;
                        prio_rd_reg  <= 1'b0;
                        state_reg    <= RD;
                    end else if (grant_wr) begin
                        id_reg       <= s_awid;
                        addr_reg     <= s_awaddr;
                        len_reg      <= s_awlen;
                        size_reg     <= s_awsize;
                        burst_reg    <= s_awburst;
                        beat_cnt_reg <= '0;
                        wr_err_reg   <= 1'b0;
                        prio_rd_reg  <= 1'b1;
                        state_reg    <= WR;
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        rvalid_reg   <= 1'b1;
                        rlast_reg    <= last_beat;
                        rresp_reg    <= beat_err ? RESP_SLVERR : RESP_OKAY;
                        rd_fresh_reg <= !beat_err;
                        if (beat_err) begin
                            rdata_hold_reg <= '0;
                        end
                        addr_reg     <= next_addr;
                        beat_cnt_reg <= beat_cnt_reg + 9'd1;
                    end else if (s_rready) begin
                        rvalid_reg <= 1'b0;
                    end
                    if (rd_done) begin
                        state_reg <= IDLE;
                    end
                end
                WR: begin
                    if (w_fire) begin
                        addr_reg     <= next_addr;
                        beat_cnt_reg <= beat_cnt_reg + 9'd1;
                        wr_err_reg   <= w_err;
                        if (w_final) begin
                            bresp_reg <= w_err ? RESP_SLVERR : RESP_OKAY;
                            state_reg <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s_bready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
